serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial adder sequencer. It accepts two WIDTH-bit operands and reuses one 1-bit add cell (half-adder pair plus carry register) for WIDTH cycles, one bit per cycle, LSB first. It produces a WIDTH-bit sum and carry-out with a start/busy/done handshake. It is the controller that time-shares the single-bit adder datapath across a multi-bit operation.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a clk edge only in IDLE or DONE
- a  input  WIDTH  operand A; captured on an accepted start
- b  input  WIDTH  operand B; captured on an accepted start
- busy  output  1  high while state is RUN
- done  output  1  single-cycle pulse; high while state is DONE
- sum  output  WIDTH  result; valid and held from DONE until the next accepted start
- cout  output  1  final carry; same validity as sum

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1: capture a and b into shift registers. Clear carry, clear sum, set bit counter to 0. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift s into the sum MSB, shifting sum right.
  - Shift a_sh and b_sh right.
  - Increment the counter.
- RUN exit: on the edge where the counter reaches WIDTH-1, move to DONE. That edge also processes the final bit and loads cout with the final carry.
- DONE: lasts exactly one cycle.
  - start=1: accepted as in IDLE, back-to-back; next state RUN.
  - start=0: next state IDLE.
- start in RUN: ignored; operands are not recaptured.
- Changes on a and b outside an accepted start edge have no effect.
- Arithmetic: {cout, sum} = a + b, modulo 2^(WIDTH+1); no truncation.
- Reset values: busy=0, done=0, sum=0, cout=0. Internal carry, counter and shift registers are 0.

## Timing
- Accepted start at edge k:
  - busy=1 from edge k through edge k+WIDTH.
  - done=1 for the cycle following edge k+WIDTH.
  - Latency is WIDTH+1 cycles, start edge to done.
- Throughput: one operation per WIDTH+1 cycles with start held high.
- sum and cout are registered outputs. Their intermediate values during RUN are undefined for consumers; only the values at done are valid.
- rst asserted at any time, including mid-RUN:
  - All outputs go immediately to their reset values and state goes to IDLE.
  - The partial result is discarded.
  - A start on the first edge after rst deasserts is accepted.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds port sub (input, 1), captured with the operands on an accepted start.
  - sub=1: the cell uses ~b and initial carry=1, computing a - b. sum = (a - b) mod 2^WIDTH. cout = 1 when a >= b (no borrow), 0 otherwise.
  - sub=0: addition, identical to the undefined build.
- SERIAL_ADD_SUB_EN undefined: no sub port; addition only.

## Test plan
- WIDTH=8, a=3, b=5, start pulsed one cycle -> busy high 8 cycles; done one cycle at start+9; sum=8, cout=0.
- a=200, b=100 -> sum=44, cout=1. Then a=255, b=1 -> sum=0, cout=1. sum and cout hold until the next start.
- start held high continuously with a=1, b=1 -> done pulses every 9 cycles, each with sum=2. Operand changes and start while busy are ignored, verified with a=7, b=9 applied mid-RUN.
- rst asserted at the 4th RUN cycle of a=170, b=85 -> outputs 0 and IDLE asynchronously. A new start with a=1, b=2 gives sum=3, cout=0.
- With SERIAL_ADD_SUB_EN: sub=1, a=10, b=3 -> sum=7, cout=1. sub=1, a=3, b=10 -> sum=249, cout=0. sub=0, a=3, b=10 -> sum=13, cout=0.

Source files
------------

// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//   Bit-serial adder sequencer. One 1-bit full-add cell (two half adders plus
//   a carry register) is reused for WIDTH cycles, LSB first, to produce a
//   WIDTH-bit sum and a carry-out.
//
//   Optional feature macro: SERIAL_ADD_SUB_EN
//     When defined, adds input 'sub'. sub=1 computes a - b by feeding ~b
//     into the cell with an initial carry of 1; cout is then the no-borrow
//     flag (a >= b).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; honoured only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   sub    in   (SERIAL_ADD_SUB_EN only) subtract select, captured with a/b
//   busy   out  high while the serial add is running
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH-bit result, held until the next accepted start
//   cout   out  final carry, same validity as sum
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Subtract select seen at the capture edge; constant 0 in the add-only build.
    logic sub_sel;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Single-bit full-add cell built from two half adders.
    logic ha0_s, ha0_c, bit_s, ha1_c, carry_next;
    assign ha0_s      = a_sh[0] ^ b_sh[0];
    assign ha0_c      = a_sh[0] & b_sh[0];
    assign bit_s      = ha0_s ^ carry;
    assign ha1_c      = ha0_s & carry;
    assign carry_next = ha0_c | ha1_c;   // majority(a, b, carry)

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b once at capture
                        // and seed the carry with the subtract flag.
                        a_sh  <= a;
                        b_sh  <= sub_sel ? ~b : b;
                        carry <= sub_sel;
                        sum   <= '0;
                        cout  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= carry_next;
                    // Result bits enter at the MSB; after WIDTH shifts bit 0
                    // has reached sum[0].
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= carry_next;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
`timescale 1ns/1ps
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic logic [W:0] ref_result(input logic [W-1:0] av, input logic [W-1:0] bv,
                                               input logic sv);
        logic [W:0] r;
        if (sv) begin
            r[W-1:0] = av - bv;
            r[W]     = (av >= bv);
        end else begin
            r = {1'b0, av} + {1'b0, bv};
        end
        return r;
    endfunction

    // Caller is at a negedge. Drives one start pulse, optionally disturbs
    // a/b/start while running, then checks handshake timing and result.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input bit noisy, input string tag);
        logic [W:0] exp;
        int n, busy_cnt;
        exp = ref_result(av, bv, sv);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (noisy) begin
                a = W'($urandom); b = W'($urandom); sub = ~sv;
                start = (n == 2);
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, n, W);
        check({tag, " busy_cycles"}, busy_cnt, W);
        check({tag, " sum"}, sum, exp[W-1:0]);
        check({tag, " cout"}, cout, exp[W]);
        // Done is one pulse; result holds while operands wiggle.
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
        check({tag, " busy_after"}, busy, 0);
        @(negedge clk);
        check({tag, " sum_hold"}, sum, exp[W-1:0]);
        check({tag, " cout_hold"}, cout, exp[W]);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(8'd3,   8'd5,   1'b0, 1'b0, "add3_5");
        do_op(8'd200, 8'd100, 1'b0, 1'b0, "add200_100");
        do_op(8'd255, 8'd1,   1'b0, 1'b0, "add255_1");
        do_op(8'd255, 8'd255, 1'b0, 1'b1, "add255_255_noisy");
        do_op(8'd0,   8'd0,   1'b0, 1'b0, "add0_0");

        // Random operands, some with disturbance while running
        for (int i = 0; i < 12; i++)
            do_op(W'($urandom), W'($urandom), 1'b0, bit'(i % 2), "rand_add");

        // start held high: back-to-back ops every W+1 cycles, with a/b
        // disturbed mid-run (restored before the DONE capture edge).
        begin
            int p;
            p = W + 1;
            a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            for (int j = 0; j < 3 * p; j++) begin
                if ((j % p) == W) begin
                    check("held done", done, 1);
                    check("held sum", sum, 2);
                    check("held cout", cout, 0);
                end else begin
                    check("held no_done", done, 0);
                    check("held busy", busy, 1);
                end
                if ((j % p) >= 2 && (j % p) <= W - 3) begin
                    a = 8'd7; b = 8'd9;
                end else begin
                    a = 8'd1; b = 8'd1;
                end
                @(negedge clk);
            end
            start = 1'b0;
            // Drain the op that was accepted at the last DONE.
            for (int j = 0; j < 2 * p && (busy || done); j++) @(negedge clk);
            check("held drained", busy, 0);
        end

        // Asynchronous reset during the 4th RUN cycle
        a = 8'd170; b = 8'd85; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst busy", busy, 0);
        check("async_rst done", done, 0);
        check("async_rst sum", sum, 0);
        check("async_rst cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd1, 8'd2, 1'b0, 1'b0, "after_rst1_2");

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'd10, 8'd3,  1'b1, 1'b0, "sub10_3");
        do_op(8'd3,  8'd10, 1'b1, 1'b0, "sub3_10");
        do_op(8'd3,  8'd10, 1'b0, 1'b0, "add3_10");
        do_op(8'd77, 8'd77, 1'b1, 1'b1, "sub_equal_noisy");
        for (int i = 0; i < 8; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand_addsub");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
